// File: rtl/gearbox_fifo.sv
// Width-converting show-ahead FIFO: accepts up to IN_SIZE words per beat, delivers OUT_SIZE
// words per beat from a circular buffer of any depth (power-of-two not required).
module gearbox_fifo #(
    parameter int DATAWIDTH = 32,
    parameter int SIZE      = 10,
    parameter int IN_SIZE   = 4,
    parameter int OUT_SIZE  = 3,
    parameter int AF_THRESH = SIZE - IN_SIZE,
    localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1,
    localparam int CW = $clog2(SIZE + 1),
    localparam int NW = $clog2(IN_SIZE + 1),
    localparam int OW = $clog2(OUT_SIZE + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [DATAWIDTH*IN_SIZE-1:0]  din,
    input  logic [NW-1:0]                 din_cnt,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic [DATAWIDTH*OUT_SIZE-1:0] dout,
    output logic [OW-1:0]                 dout_cnt,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    input  logic                          drain,
    output logic [CW-1:0]                 count,
    output logic                          empty,
    output logic                          almost_full
);

    // Handshake: a beat transfers on a rising edge where valid && ready; valid never
    // depends on ready, and the ready/valid outputs come only from registered state (and drain).

    localparam logic [AW:0]   SIZE_P = (AW + 1)'(SIZE);
    localparam logic [CW-1:0] SIZE_C = CW'(SIZE);
    localparam logic [CW-1:0] IN_C   = CW'(IN_SIZE);
    localparam logic [CW-1:0] OUT_C  = CW'(OUT_SIZE);
    localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
    localparam logic [NW-1:0] IN_N   = NW'(IN_SIZE);

    logic [DATAWIDTH-1:0] mem [SIZE];
    logic [AW-1:0]        w_addr;
    logic [AW-1:0]        r_addr;

    logic [NW-1:0] wr_n;
    logic          wr_fire;
    logic          rd_fire;
    logic [CW-1:0] add_cnt;
    logic [CW-1:0] sub_cnt;

    // Modular add without relying on power-of-two wrap; p+k never exceeds 2*SIZE-1.
    function automatic logic [AW-1:0] ptr_add(input logic [AW-1:0] p, input logic [AW:0] k);
        logic [AW:0] s;
        s = {1'b0, p} + k;
        if (s >= SIZE_P) begin
            s = s - SIZE_P;
        end
        return s[AW-1:0];
    endfunction

    assign wr_n    = (din_cnt > IN_N) ? IN_N : din_cnt;
    assign wr_fire = din_valid && din_ready && !flush;
    assign rd_fire = dout_valid && dout_ready && !flush;
    assign add_cnt = wr_fire ? CW'(wr_n) : '0;
    assign sub_cnt = rd_fire ? CW'(dout_cnt) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_addr <= '0;
            r_addr <= '0;
            count  <= '0;
        end else if (flush) begin
            w_addr <= '0;
            r_addr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) begin
                w_addr <= ptr_add(w_addr, (AW + 1)'(wr_n));
            end
            if (rd_fire) begin
                r_addr <= ptr_add(r_addr, (AW + 1)'(dout_cnt));
            end
            count <= count + add_cnt - sub_cnt;
        end
    end

    // Storage is deliberately unreset; output lane gating hides stale words.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int i = 0; i < IN_SIZE; i++) begin
                if (NW'(i) < wr_n) begin
                    mem[ptr_add(w_addr, (AW + 1)'(i))] <= din[i*DATAWIDTH +: DATAWIDTH];
                end
            end
        end
    end

    always_comb begin
        dout_valid = 1'b0;
        dout_cnt   = '0;
        if (count >= OUT_C) begin
            dout_valid = 1'b1;
            dout_cnt   = OW'(OUT_SIZE);
        end else if (drain && (count != '0)) begin
            dout_valid = 1'b1;
            dout_cnt   = OW'(count);
        end
    end

    always_comb begin
        dout = '0;
        for (int j = 0; j < OUT_SIZE; j++) begin
            if (OW'(j) < dout_cnt) begin
                dout[j*DATAWIDTH +: DATAWIDTH] = mem[ptr_add(r_addr, (AW + 1)'(j))];
            end
        end
    end

    assign din_ready   = (SIZE_C - count) >= IN_C;
    assign empty       = (count == '0);
    assign almost_full = (count >= AF_C);

endmodule

// File: tb/tb_gearbox_fifo.sv
// Directed bench for gearbox_fifo (16-bit words, SIZE=10, 4 in / 3 out): a per-cycle vector
// table checks outputs before each edge, plus a hand-written mid-transfer reset sequence.
module tb_gearbox_fifo;

    localparam int DW = 16;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic [63:0]   din;
    logic [2:0]    din_cnt;
    logic          din_valid;
    logic          din_ready;
    logic [47:0]   dout;
    logic [1:0]    dout_cnt;
    logic          dout_valid;
    logic          dout_ready;
    logic          drain;
    logic [3:0]    count;
    logic          empty;
    logic          almost_full;

    int total = 0;
    int bad   = 0;

    gearbox_fifo #(
        .DATAWIDTH(DW), .SIZE(10), .IN_SIZE(4), .OUT_SIZE(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .din(din), .din_cnt(din_cnt), .din_valid(din_valid), .din_ready(din_ready),
        .dout(dout), .dout_cnt(dout_cnt), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .drain(drain), .count(count), .empty(empty), .almost_full(almost_full)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        dv;
        logic [2:0]  dc;
        logic [63:0] din;
        logic        rdy;
        logic        drain;
        logic [3:0]  e_count;
        logic        e_empty;
        logic        e_drdy;
        logic        e_af;
        logic        e_dv;
        logic [1:0]  e_dc;
        logic [47:0] e_dout;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [63:0] p4(input logic [15:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic logic [47:0] p3(input logic [15:0] a, b, c);
        return {c, b, a};
    endfunction

    function automatic vec_t mk(input logic fl, dv, input logic [2:0] dc, input logic [63:0] d,
                                input logic rdy, dr, input logic [3:0] ec, input logic ee, er,
                                input logic ea, ev, input logic [1:0] ed, input logic [47:0] eo);
        vec_t v;
        v.flush = fl; v.dv = dv; v.dc = dc; v.din = d; v.rdy = rdy; v.drain = dr;
        v.e_count = ec; v.e_empty = ee; v.e_drdy = er; v.e_af = ea;
        v.e_dv = ev; v.e_dc = ed; v.e_dout = eo;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        check({tag, " count"},       64'(count),       64'(v.e_count));
        check({tag, " empty"},       64'(empty),       64'(v.e_empty));
        check({tag, " din_ready"},   64'(din_ready),   64'(v.e_drdy));
        check({tag, " almost_full"}, 64'(almost_full), 64'(v.e_af));
        check({tag, " dout_valid"},  64'(dout_valid),  64'(v.e_dv));
        check({tag, " dout_cnt"},    64'(dout_cnt),    64'(v.e_dc));
        check({tag, " dout"},        64'(dout),        64'(v.e_dout));
    endtask

    // driver: inputs change on the falling edge, outputs are sampled 1 ns later
    task automatic drive(input vec_t v);
        flush      = v.flush;
        din_valid  = v.dv;
        din_cnt    = v.dc;
        din        = v.din;
        dout_ready = v.rdy;
        drain      = v.drain;
    endtask

    task automatic idle_inputs();
        flush = 0; din_valid = 0; din_cnt = 0; din = '0; dout_ready = 0; drain = 0;
    endtask

    vec_t rst_exp;
    vec_t cur;

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        rst_exp = mk(0,0,0,0, 0,0, 4'd0,1,1,0,0,2'd0,48'h0);

        // columns: flush dv dc din | rdy drain | count empty din_ready af dout_valid dout_cnt dout
        // scenario 2: two full writes, then read two beats; v3 also tries a blocked write
        vecs.push_back(mk(0,0,0,0,                        0,0, 0,1,1,0,0,0,0));
        vecs.push_back(mk(0,1,4,p4('h1,'h2,'h3,'h4),     0,0, 0,1,1,0,0,0,0));
        vecs.push_back(mk(0,1,4,p4('h5,'h6,'h7,'h8),     0,0, 4,0,1,0,1,3,p3('h1,'h2,'h3)));
        vecs.push_back(mk(0,1,4,p4('hee,'hee,'hee,'hee), 1,0, 8,0,0,1,1,3,p3('h1,'h2,'h3)));
        vecs.push_back(mk(0,0,0,0,                        1,0, 5,0,1,0,1,3,p3('h4,'h5,'h6)));
        vecs.push_back(mk(0,0,0,0,                        0,0, 2,0,1,0,0,0,0));
        // scenario 3: write wraps over the end of storage, reads wrap too
        vecs.push_back(mk(0,1,4,p4('h9,'ha,'hb,'hc),     0,0, 2,0,1,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,                        1,0, 6,0,1,1,1,3,p3('h7,'h8,'h9)));
        vecs.push_back(mk(0,0,0,0,                        1,0, 3,0,1,0,1,3,p3('ha,'hb,'hc)));
        vecs.push_back(mk(0,0,0,0,                        1,0, 0,1,1,0,0,0,0));
        // scenario 4: partial write, drain exposes the short beat with lane 2 zeroed
        vecs.push_back(mk(0,1,2,p4('ha1,'hb2,'hdd,'hdd), 0,0, 0,1,1,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,                        0,0, 2,0,1,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,                        0,1, 2,0,1,0,1,2,p3('ha1,'hb2,'h0)));
        vecs.push_back(mk(0,0,0,0,                        1,1, 2,0,1,0,1,2,p3('ha1,'hb2,'h0)));
        vecs.push_back(mk(0,0,0,0,                        0,1, 0,1,1,0,0,0,0));
        // scenario 5: build count=6, then concurrent write+read, then clamped din_cnt=7
        vecs.push_back(mk(0,1,4,p4('h11,'h12,'h13,'h14), 0,0, 0,1,1,0,0,0,0));
        vecs.push_back(mk(0,1,2,p4('h15,'h16,'hdd,'hdd), 0,0, 4,0,1,0,1,3,p3('h11,'h12,'h13)));
        vecs.push_back(mk(0,1,3,p4('h17,'h18,'h19,'hdd), 1,0, 6,0,1,1,1,3,p3('h11,'h12,'h13)));
        vecs.push_back(mk(0,1,7,p4('h1a,'h1b,'h1c,'h1d), 1,0, 6,0,1,1,1,3,p3('h14,'h15,'h16)));
        vecs.push_back(mk(0,0,0,0,                        1,0, 7,0,0,1,1,3,p3('h17,'h18,'h19)));
        vecs.push_back(mk(0,0,0,0,                        1,0, 4,0,1,0,1,3,p3('h1a,'h1b,'h1c)));
        // scenario 6: reach count=5, flush with write and read both requested
        vecs.push_back(mk(0,1,4,p4('h21,'h22,'h23,'h24), 0,0, 1,0,1,0,0,0,0));
        vecs.push_back(mk(1,1,4,p4('h31,'h32,'h33,'h34), 1,0, 5,0,1,0,1,3,p3('h1d,'h21,'h22)));
        vecs.push_back(mk(0,0,0,0,                        0,0, 0,1,1,0,0,0,0));
        vecs.push_back(mk(0,1,3,p4('h41,'h42,'h43,'hdd), 0,0, 0,1,1,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,                        0,0, 3,0,1,0,1,3,p3('h41,'h42,'h43)));
        vecs.push_back(mk(0,0,0,0,                        1,0, 3,0,1,0,1,3,p3('h41,'h42,'h43)));
        // zero-count write is a no-op
        vecs.push_back(mk(0,1,0,p4('h51,'h52,'h53,'h54), 0,0, 0,1,1,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,                        0,0, 0,1,1,0,0,0,0));

        // reset check, during and after reset
        repeat (2) @(negedge clk);
        #1 check_outputs("reset_active", rst_exp);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_outputs("reset_release", rst_exp);

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            cur = vecs[k];
            drive(cur);
            #1 check_outputs($sformatf("vec%0d", k), cur);
        end

        // mid-transfer asynchronous reset discards contents immediately
        @(negedge clk);
        idle_inputs();
        din_valid = 1; din_cnt = 4; din = p4('h61, 'h62, 'h63, 'h64);
        @(negedge clk);
        idle_inputs();
        #1 check("pre_reset count", 64'(count), 64'd4);
        #2 rst_n = 1'b0;
        #1 check_outputs("async_reset", rst_exp);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1 check_outputs("after_async_reset", rst_exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
